stage_decode_buf: RTL and testbench

//  RV32I decode stage, second generation: decoupled from IF and EX by valid/ready handshakes.

---
 rtl/stage_decode_buf.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_stage_decode_buf.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_decode_buf.sv
// RV32I decode stage with an instruction queue between IF and decode and a one-entry ID-EX register.
// Handles the load-use interlock, JAL redirect and wrong-path flush; PC_W is limited to 32 bits.

package stage_decode_buf_pkg;
    localparam logic [1:0] SEL_A_RS1  = 2'd0;
    localparam logic [1:0] SEL_A_PC   = 2'd1;
    localparam logic [1:0] SEL_A_ZERO = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  reg_wr_addr;
        logic        reg_wr_en;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        dmem_rd_en;
        logic        dmem_wr_en;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        ex_ma_intlk;
        logic        illegal;
    } id_ex_reg_t;
endpackage

module instr_decoder (
    input  logic [31:0] instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        rd_wr,
    output logic [31:0] imm,
    output logic [31:0] imm_j,
    output logic [3:0]  alu_op,
    output logic [2:0]  funct3,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic [1:0]  sel_a,
    output logic        sel_b_imm,
    output logic        illegal
);
    logic [6:0]  w_opcode;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;

    assign w_opcode = instr[6:0];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign rd_addr  = instr[11:7];
    assign funct3   = instr[14:12];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u  = {instr[31:12], 12'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        rd_wr     = 1'b0;
        imm       = 32'd0;
        alu_op    = 4'd0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        branch    = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        sel_a     = stage_decode_buf_pkg::SEL_A_RS1;
        sel_b_imm = 1'b1;
        illegal   = 1'b0;
        case (w_opcode)
            7'b0110111: begin
                rd_wr = 1'b1;
                imm   = w_imm_u;
                sel_a = stage_decode_buf_pkg::SEL_A_ZERO;
            end
            7'b0010111: begin
                rd_wr = 1'b1;
                imm   = w_imm_u;
                sel_a = stage_decode_buf_pkg::SEL_A_PC;
            end
            7'b1101111: begin
                rd_wr = 1'b1;
                jal   = 1'b1;
                imm   = imm_j;
                sel_a = stage_decode_buf_pkg::SEL_A_PC;
            end
            7'b1100111: begin
                rd_wr    = 1'b1;
                jalr     = 1'b1;
                rs1_used = 1'b1;
                imm      = w_imm_i;
            end
            7'b1100011: begin
                branch    = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                imm       = w_imm_b;
                sel_b_imm = 1'b0;
            end
            7'b0000011: begin
                rd_wr    = 1'b1;
                dmem_rd  = 1'b1;
                rs1_used = 1'b1;
                imm      = w_imm_i;
            end
            7'b0100011: begin
                dmem_wr  = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm      = w_imm_s;
            end
            7'b0010011: begin
                rd_wr    = 1'b1;
                rs1_used = 1'b1;
                imm      = w_imm_i;
                // Only SRAI carries a funct7 qualifier among the immediate ops
                alu_op   = {(instr[14:12] == 3'b101) & instr[30], instr[14:12]};
            end
            7'b0110011: begin
                rd_wr     = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                sel_b_imm = 1'b0;
                alu_op    = {instr[30], instr[14:12]};
            end
            7'b0001111, 7'b1110011: begin
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

module stage_decode_buf
    import stage_decode_buf_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int PC_W   = 32,
    parameter int HAZ_EN = 1
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] pc4_i,
    input  logic            squash_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [31:0]     data_rs1_i,
    input  logic [31:0]     data_rs2_i,
    input  logic            ex_ld_valid_i,
    input  logic [4:0]      ex_ld_rd_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output id_ex_reg_t      id_ex_o,
    output logic            jal_o,
    output logic [PC_W-1:0] jal_addr_o
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [31:0]      r_q_instr [QDEPTH];
    logic [PC_W-1:0]  r_q_pc    [QDEPTH];
    logic [PC_W-1:0]  r_q_pc4   [QDEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_vld_p1;
    id_ex_reg_t       r_id_ex_p1;

    logic [31:0]      w_head_instr;
    logic [PC_W-1:0]  w_head_pc;
    logic [PC_W-1:0]  w_head_pc4;
    logic             w_nonempty;
    logic             w_push;
    logic             w_push_eff;
    logic             w_issue;
    logic             w_hazard;
    logic             w_flush;

    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_rd;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_rd_wr;
    logic [31:0]      w_imm;
    logic [31:0]      w_imm_j;
    logic [3:0]       w_alu_op;
    logic [2:0]       w_funct3;
    logic             w_dmem_rd;
    logic             w_dmem_wr;
    logic             w_branch;
    logic             w_is_jal;
    logic             w_is_jalr;
    logic [1:0]       w_sel_a;
    logic             w_sel_b_imm;
    logic             w_illegal;
    id_ex_reg_t       w_dec;

    // ---- queue head / decode ----
    assign w_head_instr = r_q_instr[r_rd_ptr];
    assign w_head_pc    = r_q_pc[r_rd_ptr];
    assign w_head_pc4   = r_q_pc4[r_rd_ptr];
    assign w_nonempty   = (r_count != '0);

    instr_decoder u_dec (
        .instr     (w_head_instr),
        .rs1_addr  (w_rs1),
        .rs2_addr  (w_rs2),
        .rd_addr   (w_rd),
        .rs1_used  (w_rs1_used),
        .rs2_used  (w_rs2_used),
        .rd_wr     (w_rd_wr),
        .imm       (w_imm),
        .imm_j     (w_imm_j),
        .alu_op    (w_alu_op),
        .funct3    (w_funct3),
        .dmem_rd   (w_dmem_rd),
        .dmem_wr   (w_dmem_wr),
        .branch    (w_branch),
        .jal       (w_is_jal),
        .jalr      (w_is_jalr),
        .sel_a     (w_sel_a),
        .sel_b_imm (w_sel_b_imm),
        .illegal   (w_illegal)
    );

    assign rs1_addr_o = w_rs1;
    assign rs2_addr_o = w_rs2;

    always_comb begin
        w_dec             = '0;
        w_dec.pc          = 32'(w_head_pc);
        w_dec.pc4         = 32'(w_head_pc4);
        w_dec.rs1_data    = data_rs1_i;
        w_dec.rs2_data    = data_rs2_i;
        w_dec.imm         = w_imm;
        w_dec.rs1_addr    = w_rs1;
        w_dec.rs2_addr    = w_rs2;
        w_dec.reg_wr_addr = w_rd;
        w_dec.reg_wr_en   = w_rd_wr && (w_rd != 5'd0);
        w_dec.alu_op      = w_alu_op;
        w_dec.funct3      = w_funct3;
        w_dec.dmem_rd_en  = w_dmem_rd;
        w_dec.dmem_wr_en  = w_dmem_wr;
        w_dec.branch      = w_branch;
        w_dec.jal         = w_is_jal;
        w_dec.jalr        = w_is_jalr;
        w_dec.ex_ma_intlk = w_is_jal | w_dmem_rd;
        w_dec.illegal     = w_illegal;
        case (w_sel_a)
            SEL_A_PC:   w_dec.op_a = 32'(w_head_pc);
            SEL_A_ZERO: w_dec.op_a = 32'd0;
            default:    w_dec.op_a = data_rs1_i;
        endcase
        w_dec.op_b = w_sel_b_imm ? w_imm : data_rs2_i;
    end

    // Load-use: a load either still in the ID-EX register or already in EX
    function automatic logic ld_hit(input logic [4:0] rs, input logic ex_ld_v,
                                    input logic [4:0] ex_ld_rd, input logic id_ld_v,
                                    input logic [4:0] id_ld_rd);
        return (ex_ld_v && (ex_ld_rd != 5'd0) && (ex_ld_rd == rs)) ||
               (id_ld_v && (id_ld_rd != 5'd0) && (id_ld_rd == rs));
    endfunction

    always_comb begin
        logic w_id_ld;
        w_id_ld  = r_vld_p1 && r_id_ex_p1.dmem_rd_en;
        w_hazard = 1'b0;
        if (HAZ_EN != 0 && w_nonempty) begin
            w_hazard = (w_rs1_used && ld_hit(w_rs1, ex_ld_valid_i, ex_ld_rd_i,
                                             w_id_ld, r_id_ex_p1.reg_wr_addr)) ||
                       (w_rs2_used && ld_hit(w_rs2, ex_ld_valid_i, ex_ld_rd_i,
                                             w_id_ld, r_id_ex_p1.reg_wr_addr));
        end
    end

    assign if_ready_o = (r_count != CNT_W'(QDEPTH));
    assign w_issue    = w_nonempty && !w_hazard && (!r_vld_p1 || ex_ready_i) && !squash_i;
    assign jal_o      = w_issue && w_is_jal;
    assign jal_addr_o = w_head_pc + w_imm_j[PC_W-1:0];
    assign w_flush    = squash_i || jal_o;
    assign w_push     = if_valid_i && if_ready_o;
    assign w_push_eff = w_push && !w_flush;

    // ---- queue control ----
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push_eff) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_issue)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_eff, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_q_instr[r_wr_ptr] <= instr_i;
            r_q_pc[r_wr_ptr]    <= pc_i;
            r_q_pc4[r_wr_ptr]   <= pc4_i;
        end
    end

    // ---- ID-EX register (p1) ----
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p1 <= 1'b0;
        end else if (squash_i) begin
            r_vld_p1 <= 1'b0;
        end else if (w_issue) begin
            r_vld_p1 <= 1'b1;
        end else if (ex_ready_i) begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_id_ex_p1 <= w_dec;
    end

    assign ex_valid_o = r_vld_p1;
    assign id_ex_o    = r_id_ex_p1;
endmodule

// File: tb/tb_stage_decode_buf.sv
// Directed bench for stage_decode_buf: streaming, backpressure, load-use, JAL flush, squash, async reset.
// A second instance with the interlock disabled shares all inputs.

module tb_stage_decode_buf;
    import stage_decode_buf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] pc4;
    logic        squash = 1'b0;
    logic        ex_ld_valid = 1'b0;
    logic [4:0]  ex_ld_rd = 5'd0;
    logic        ex_ready = 1'b1;

    logic        if_ready0, ex_valid0, jal0;
    logic [4:0]  rs1a0, rs2a0;
    logic [31:0] rs1d0, rs2d0, jal_addr0;
    id_ex_reg_t  id_ex0;

    logic        if_ready1, ex_valid1, jal1;
    logic [4:0]  rs1a1, rs2a1;
    logic [31:0] rs1d1, rs2d1, jal_addr1;
    id_ex_reg_t  id_ex1;

    int n_total = 0;
    int n_pass  = 0;

    assign pc4   = pc + 32'd4;
    assign rs1d0 = 32'hA000_0000 | {27'd0, rs1a0};
    assign rs2d0 = 32'hB000_0000 | {27'd0, rs2a0};
    assign rs1d1 = 32'hA000_0000 | {27'd0, rs1a1};
    assign rs2d1 = 32'hB000_0000 | {27'd0, rs2a1};

    always #5 clk = ~clk;

    stage_decode_buf #(.QDEPTH(2), .PC_W(32), .HAZ_EN(1)) dut (
        .clk(clk), .rst_ni(rst_ni), .if_valid_i(if_valid), .if_ready_o(if_ready0),
        .instr_i(instr), .pc_i(pc), .pc4_i(pc4), .squash_i(squash),
        .rs1_addr_o(rs1a0), .rs2_addr_o(rs2a0), .data_rs1_i(rs1d0), .data_rs2_i(rs2d0),
        .ex_ld_valid_i(ex_ld_valid), .ex_ld_rd_i(ex_ld_rd), .ex_valid_o(ex_valid0),
        .ex_ready_i(ex_ready), .id_ex_o(id_ex0), .jal_o(jal0), .jal_addr_o(jal_addr0)
    );

    stage_decode_buf #(.QDEPTH(2), .PC_W(32), .HAZ_EN(0)) dut_nohaz (
        .clk(clk), .rst_ni(rst_ni), .if_valid_i(if_valid), .if_ready_o(if_ready1),
        .instr_i(instr), .pc_i(pc), .pc4_i(pc4), .squash_i(squash),
        .rs1_addr_o(rs1a1), .rs2_addr_o(rs2a1), .data_rs1_i(rs1d1), .data_rs2_i(rs2d1),
        .ex_ld_valid_i(ex_ld_valid), .ex_ld_rd_i(ex_ld_rd), .ex_valid_o(ex_valid1),
        .ex_ready_i(ex_ready), .id_ex_o(id_ex1), .jal_o(jal1), .jal_addr_o(jal_addr1)
    );

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
        if_valid = v;
        instr    = ins;
        pc       = p;
    endtask

    initial begin
        // Reset asserted before any clock edge
        #2 rst_ni = 1'b0;
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid0}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready0}, 32'd1);
        chk("rst_jal", {31'd0, jal0}, 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;

        // Streaming ADDI with EX always ready
        ex_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            drive(k < 4, enc_addi(5'(k + 1), 5'(k + 2), 12'(k + 10)), 32'h100 + 32'(4 * k));
            tick();
            chk("strm_if_ready", {31'd0, if_ready0}, 32'd1);
            if (k == 0) begin
                chk("strm_fill", {31'd0, ex_valid0}, 32'd0);
            end else begin
                chk("strm_valid", {31'd0, ex_valid0}, 32'd1);
                chk("strm_pc", id_ex0.pc, 32'h100 + 32'(4 * (k - 1)));
                chk("strm_rd", {27'd0, id_ex0.reg_wr_addr}, 32'(k));
                chk("strm_imm", id_ex0.imm, 32'(k + 9));
                chk("strm_op_a", id_ex0.op_a, 32'hA000_0000 + 32'(k + 1));
                chk("strm_op_b", id_ex0.op_b, 32'(k + 9));
            end
        end
        tick();
        chk("strm_drain", {31'd0, ex_valid0}, 32'd0);

        // Backpressure: EX stalled for five edges while IF keeps presenting
        ex_ready = 1'b0;
        drive(1'b1, enc_addi(5'd10, 5'd0, 12'd0), 32'h200);
        tick();
        chk("bp_if_ready_1", {31'd0, if_ready0}, 32'd1);
        drive(1'b1, enc_addi(5'd11, 5'd0, 12'd1), 32'h204);
        tick();
        chk("bp_valid", {31'd0, ex_valid0}, 32'd1);
        chk("bp_pc0", id_ex0.pc, 32'h200);
        drive(1'b1, enc_addi(5'd12, 5'd0, 12'd2), 32'h208);
        tick();
        chk("bp_full", {31'd0, if_ready0}, 32'd0);
        drive(1'b1, enc_addi(5'd13, 5'd0, 12'd3), 32'h20C);
        tick();
        chk("bp_full_hold", {31'd0, if_ready0}, 32'd0);
        tick();
        chk("bp_stable_pc", id_ex0.pc, 32'h200);
        chk("bp_stable_rd", {27'd0, id_ex0.reg_wr_addr}, 32'd10);
        chk("bp_stable_v", {31'd0, ex_valid0}, 32'd1);
        ex_ready = 1'b1;
        tick();
        chk("bp_rel_pc1", id_ex0.pc, 32'h204);
        chk("bp_rel_ready", {31'd0, if_ready0}, 32'd1);
        tick();
        chk("bp_rel_pc2", id_ex0.pc, 32'h208);
        if_valid = 1'b0;
        tick();
        chk("bp_rel_pc3", id_ex0.pc, 32'h20C);
        chk("bp_rel_imm3", id_ex0.imm, 32'd3);
        tick();
        chk("bp_drain", {31'd0, ex_valid0}, 32'd0);

        // Load-use: LW x5,0(x1) then ADD x6,x5,x1
        drive(1'b1, enc_lw(5'd5, 5'd1, 12'd0), 32'h300);
        tick();
        drive(1'b1, enc_add(5'd6, 5'd5, 5'd1), 32'h304);
        tick();
        if_valid = 1'b0;
        chk("lu_lw_valid", {31'd0, ex_valid0}, 32'd1);
        chk("lu_lw_rd_en", {31'd0, id_ex0.dmem_rd_en}, 32'd1);
        chk("lu_lw_intlk", {31'd0, id_ex0.ex_ma_intlk}, 32'd1);
        chk("lu_head_rs1", {27'd0, rs1a0}, 32'd5);
        tick();
        chk("lu_bubble_idex", {31'd0, ex_valid0}, 32'd0);
        chk("lu_nohaz_issue", {31'd0, ex_valid1}, 32'd1);
        chk("lu_nohaz_pc", id_ex1.pc, 32'h304);
        ex_ld_valid = 1'b1;
        ex_ld_rd    = 5'd5;
        tick();
        chk("lu_bubble_ex", {31'd0, ex_valid0}, 32'd0);
        ex_ld_valid = 1'b0;
        ex_ld_rd    = 5'd0;
        tick();
        chk("lu_add_valid", {31'd0, ex_valid0}, 32'd1);
        chk("lu_add_pc", id_ex0.pc, 32'h304);
        chk("lu_add_op_a", id_ex0.op_a, 32'hA000_0005);
        chk("lu_add_op_b", id_ex0.op_b, 32'hB000_0001);
        chk("lu_add_intlk", {31'd0, id_ex0.ex_ma_intlk}, 32'd0);
        tick();

        // JAL at head of a full queue with a push pending
        ex_ready = 1'b0;
        drive(1'b1, enc_addi(5'd2, 5'd0, 12'd1), 32'h400);
        tick();
        drive(1'b1, enc_jal(5'd1, 21'h00020), 32'h404);
        tick();
        drive(1'b1, enc_addi(5'd3, 5'd0, 12'd7), 32'h408);
        tick();
        chk("jal_full", {31'd0, if_ready0}, 32'd0);
        chk("jal_stalled", {31'd0, jal0}, 32'd0);
        drive(1'b1, enc_addi(5'd4, 5'd0, 12'd9), 32'h40C);
        ex_ready = 1'b1;
        #1;
        chk("jal_fire", {31'd0, jal0}, 32'd1);
        chk("jal_addr", jal_addr0, 32'h424);
        tick();
        if_valid = 1'b0;
        chk("jal_issued", {31'd0, ex_valid0}, 32'd1);
        chk("jal_pc", id_ex0.pc, 32'h404);
        chk("jal_wr_en", {31'd0, id_ex0.reg_wr_en}, 32'd1);
        chk("jal_intlk", {31'd0, id_ex0.ex_ma_intlk}, 32'd1);
        chk("jal_one_cycle", {31'd0, jal0}, 32'd0);
        chk("jal_empty", {31'd0, if_ready0}, 32'd1);
        tick();
        chk("jal_younger_gone", {31'd0, ex_valid0}, 32'd0);

        // JAL x0 with a same-cycle push: push dropped, rd write suppressed
        drive(1'b1, enc_jal(5'd0, 21'h1FFFF8), 32'h500);
        tick();
        drive(1'b1, enc_addi(5'd7, 5'd0, 12'd5), 32'h504);
        #1;
        chk("jal0_fire", {31'd0, jal0}, 32'd1);
        chk("jal0_addr", jal_addr0, 32'h4F8);
        tick();
        if_valid = 1'b0;
        chk("jal0_pc", id_ex0.pc, 32'h500);
        chk("jal0_wr_en", {31'd0, id_ex0.reg_wr_en}, 32'd0);
        tick();
        chk("jal0_push_dropped", {31'd0, ex_valid0}, 32'd0);

        // Squash with a full queue and a valid output register
        ex_ready = 1'b0;
        drive(1'b1, enc_addi(5'd8, 5'd0, 12'd1), 32'h600);
        tick();
        drive(1'b1, enc_addi(5'd9, 5'd0, 12'd2), 32'h604);
        tick();
        drive(1'b1, enc_addi(5'd10, 5'd0, 12'd3), 32'h608);
        tick();
        chk("sq_pre_full", {31'd0, if_ready0}, 32'd0);
        chk("sq_pre_valid", {31'd0, ex_valid0}, 32'd1);
        squash = 1'b1;
        drive(1'b1, enc_addi(5'd11, 5'd0, 12'd4), 32'h60C);
        tick();
        chk("sq_valid_clr", {31'd0, ex_valid0}, 32'd0);
        chk("sq_empty", {31'd0, if_ready0}, 32'd1);
        squash   = 1'b0;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        chk("sq_no_issue", {31'd0, ex_valid0}, 32'd0);

        // Squash overrides a JAL at head and drops the same-cycle push
        drive(1'b1, enc_jal(5'd1, 21'h00010), 32'h680);
        tick();
        squash = 1'b1;
        drive(1'b1, enc_addi(5'd12, 5'd0, 12'd5), 32'h684);
        #1;
        chk("sq_jal_blocked", {31'd0, jal0}, 32'd0);
        tick();
        chk("sq2_valid", {31'd0, ex_valid0}, 32'd0);
        squash   = 1'b0;
        if_valid = 1'b0;
        #1;
        chk("sq2_head_gone", {31'd0, jal0}, 32'd0);
        tick();
        chk("sq2_push_dropped", {31'd0, ex_valid0}, 32'd0);

        // Asynchronous reset mid-stream
        ex_ready = 1'b0;
        drive(1'b1, enc_addi(5'd13, 5'd0, 12'd1), 32'h700);
        tick();
        drive(1'b1, enc_addi(5'd14, 5'd0, 12'd2), 32'h704);
        tick();
        drive(1'b1, enc_addi(5'd15, 5'd0, 12'd3), 32'h708);
        tick();
        chk("ar_pre_valid", {31'd0, ex_valid0}, 32'd1);
        chk("ar_pre_full", {31'd0, if_ready0}, 32'd0);
        #3 rst_ni = 1'b0;
        #1;
        chk("ar_valid", {31'd0, ex_valid0}, 32'd0);
        chk("ar_ready", {31'd0, if_ready0}, 32'd1);
        tick();
        rst_ni   = 1'b1;
        ex_ready = 1'b1;
        drive(1'b1, enc_addi(5'd16, 5'd0, 12'd6), 32'h740);
        tick();
        if_valid = 1'b0;
        chk("ar_first_push_lat", {31'd0, ex_valid0}, 32'd0);
        tick();
        chk("ar_first_push_v", {31'd0, ex_valid0}, 32'd1);
        chk("ar_first_push_pc", id_ex0.pc, 32'h740);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
